// File: rtl/fifo_stream_pkg.sv
// Shared types and constants for the FIFO stream reader.
//   BUF_DEPTH  : entries in the output buffer (also the read credit limit)
//   LINE_CNT_W : width of the line word counter
//   buf_entry_t: one buffered stream word {data, last}
//   credit_ok  : true when another FIFO read may be issued
package fifo_stream_pkg;

    localparam int BUF_DEPTH  = 4;
    localparam int LINE_CNT_W = 16;
    localparam int STREAM_DW  = 32;
    localparam int OCC_W      = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W      = $clog2(BUF_DEPTH);

    typedef struct packed {
        logic [STREAM_DW-1:0] data;
        logic                 last;
    } buf_entry_t;

    // Every issued read owns a buffer slot until it is popped, so the sum
    // of reads in flight and words held must stay below the buffer depth.
    function automatic logic credit_ok(input logic [OCC_W-1:0] inflight_cnt,
                                       input logic [OCC_W-1:0] occ);
        return ({1'b0, inflight_cnt} + {1'b0, occ}) < (OCC_W + 1)'(BUF_DEPTH);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Valid/ready stream carrying one FIFO word plus a line-end marker.
//   m_valid/m_data/m_last : driven by the master (the reader)
//   m_ready               : driven by the slave (downstream consumer)
interface fifo_stream_reader_if
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = STREAM_DW
);
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;

    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
endinterface

// File: rtl/fifo_stream_skid_buf.sv
// Register-based 4-entry buffer of {data, last} words.
//   push/push_entry : write one entry at the tail
//   pop             : drop the head entry
//   head            : current head entry (valid when occ != 0)
//   occ             : number of entries held
// The caller guarantees no push when full and no pop when empty.
module fifo_stream_skid_buf
    import fifo_stream_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  buf_entry_t       push_entry,
    input  logic             pop,
    output buf_entry_t       head,
    output logic [OCC_W-1:0] occ
);

    buf_entry_t       mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because BUF_DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            occ <= occ + OCC_W'(push) - OCC_W'(pop);
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side controller for a synchronous 32-bit FIFO. Issues credit-limited
// reads, absorbs the FIFO read latency in a small buffer and presents the
// words as a valid/ready stream with a line-end marker.
//   clk, rst_n     : clock, asynchronous active-low reset
//   enable         : permits new FIFO reads
//   fifo_empty     : registered FIFO empty flag
//   fifo_rd_en     : FIFO read strobe
//   fifo_rd_data   : FIFO read data, valid RD_LATENCY cycles after the strobe
//   m_if           : output stream (master side)
//   busy           : a word is in flight or buffered
module fifo_stream_reader
    import fifo_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,    // 1 or 2
    parameter int LINE_WORDS = 1024  // 1..65535
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    fifo_stream_reader_if.master  m_if,
    output logic                  busy
);

    logic [RD_LATENCY-1:0] inflight;
    logic [OCC_W-1:0]      inflight_cnt;
    logic [OCC_W-1:0]      occ;
    logic [LINE_CNT_W-1:0] line_cnt;
    logic                  push;
    logic                  pop;
    logic                  line_end;
    buf_entry_t            push_entry;
    buf_entry_t            head;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++)
            inflight_cnt = inflight_cnt + OCC_W'(inflight[i]);
    end

    // rst_n is folded in so the strobe drops the moment reset is asserted,
    // not one edge later.
    assign fifo_rd_en = rst_n & enable & ~fifo_empty & credit_ok(inflight_cnt, occ);

    // Each bit marks a read issued that many cycles ago; the top bit is the
    // read whose data is on fifo_rd_data this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) inflight <= '0;
        else        inflight <= (inflight << 1) | RD_LATENCY'(fifo_rd_en);
    end

    assign push     = inflight[RD_LATENCY-1];
    assign line_end = (line_cnt == LINE_CNT_W'(LINE_WORDS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    line_cnt <= '0;
        else if (push) line_cnt <= line_end ? '0 : line_cnt + LINE_CNT_W'(1);
    end

    assign push_entry.data = fifo_rd_data;
    assign push_entry.last = line_end;

    fifo_stream_skid_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .occ        (occ)
    );

    assign m_if.m_valid = (occ != '0);
    assign m_if.m_data  = head.data;
    assign m_if.m_last  = head.last;
    assign pop          = m_if.m_valid & m_if.m_ready;
    assign busy         = (inflight != '0) | (occ != '0);

endmodule

// File: tb/tb_fifo_stream_reader.sv
module tb_fifo_stream_reader;

    localparam int NI = 3;  // 0: lat1/1024, 1: lat2/1024, 2: lat1/4

    logic clk_tb = 1'b0;
    logic tb_rst = 1'b0;
    always #5 clk_tb = ~clk_tb;

    logic [NI-1:0] enable    = '0;
    logic [NI-1:0] m_ready_v = '1;
    logic [NI-1:0] fempty    = '1;
    logic [NI-1:0] rd_en, busy_v, valid_v, last_v;
    logic [31:0]   rd_data [NI];
    logic [31:0]   data_v  [NI];

    int checks = 0;
    int failures = 0;

    function automatic int lat_of(input int k);
        return (k == 1) ? 2 : 1;
    endfunction
    function automatic int lw_of(input int k);
        return (k == 2) ? 4 : 1024;
    endfunction

    fifo_stream_reader_if #(.DATA_WIDTH(32)) sif0 ();
    fifo_stream_reader_if #(.DATA_WIDTH(32)) sif1 ();
    fifo_stream_reader_if #(.DATA_WIDTH(32)) sif2 ();

    assign sif0.m_ready = m_ready_v[0];
    assign sif1.m_ready = m_ready_v[1];
    assign sif2.m_ready = m_ready_v[2];
    assign valid_v = {sif2.m_valid, sif1.m_valid, sif0.m_valid};
    assign last_v  = {sif2.m_last, sif1.m_last, sif0.m_last};
    assign data_v[0] = sif0.m_data;
    assign data_v[1] = sif1.m_data;
    assign data_v[2] = sif2.m_data;

    fifo_stream_reader #(.DATA_WIDTH(32), .RD_LATENCY(1), .LINE_WORDS(1024)) u0 (
        .clk(clk_tb), .rst_n(tb_rst), .enable(enable[0]), .fifo_empty(fempty[0]),
        .fifo_rd_en(rd_en[0]), .fifo_rd_data(rd_data[0]), .m_if(sif0), .busy(busy_v[0]));
    fifo_stream_reader #(.DATA_WIDTH(32), .RD_LATENCY(2), .LINE_WORDS(1024)) u1 (
        .clk(clk_tb), .rst_n(tb_rst), .enable(enable[1]), .fifo_empty(fempty[1]),
        .fifo_rd_en(rd_en[1]), .fifo_rd_data(rd_data[1]), .m_if(sif1), .busy(busy_v[1]));
    fifo_stream_reader #(.DATA_WIDTH(32), .RD_LATENCY(1), .LINE_WORDS(4)) u2 (
        .clk(clk_tb), .rst_n(tb_rst), .enable(enable[2]), .fifo_empty(fempty[2]),
        .fifo_rd_en(rd_en[2]), .fifo_rd_data(rd_data[2]), .m_if(sif2), .busy(busy_v[2]));

    // FIFO models: registered empty flag, 1 or 2 cycle read latency, never reset.
    logic [31:0] fmem [NI][4096];
    logic [31:0] s1 [NI];
    logic [31:0] s2 [NI];
    int wp [NI];
    int rp [NI];
    int viol_fifo = 0;

    always @(posedge clk_tb) begin
        for (int k = 0; k < NI; k++) begin
            if (rd_en[k]) begin
                if (rp[k] == wp[k]) viol_fifo <= viol_fifo + 1;
                s1[k] <= fmem[k][rp[k] % 4096];
                rp[k] <= rp[k] + 1;
            end
            s2[k]     <= s1[k];
            fempty[k] <= (wp[k] == rp[k] + (rd_en[k] ? 1 : 0));
        end
    end

    always_comb begin
        for (int k = 0; k < NI; k++) rd_data[k] = (lat_of(k) == 2) ? s2[k] : s1[k];
    end

    // Stream monitor: collects accepted words, tracks outstanding reads
    // (issued but not yet accepted) and flags protocol violations.
    logic [32:0]   out_q [NI][$];
    int            outst [NI];
    int            nrd   [NI];
    logic [NI-1:0] stall = '0;
    logic [31:0]   hold_d [NI];
    logic [NI-1:0] hold_l;
    int            viol_mon = 0;

    always @(negedge clk_tb) begin
        for (int k = 0; k < NI; k++) begin
            if (rd_en[k]) nrd[k] <= nrd[k] + 1;
            if (!tb_rst) begin
                outst[k] <= 0;
                stall[k] <= 1'b0;
            end else begin
                if (rd_en[k] && outst[k] >= 4) viol_mon <= viol_mon + 1;
                if (busy_v[k] !== (outst[k] != 0)) viol_mon <= viol_mon + 1;
                if (stall[k] && (valid_v[k] !== 1'b1 || data_v[k] !== hold_d[k] ||
                                 last_v[k] !== hold_l[k]))
                    viol_mon <= viol_mon + 1;
                stall[k]  <= valid_v[k] & ~m_ready_v[k];
                hold_d[k] <= data_v[k];
                hold_l[k] <= last_v[k];
                if (valid_v[k] && m_ready_v[k]) out_q[k].push_back({last_v[k], data_v[k]});
                outst[k] <= outst[k] + (rd_en[k] ? 1 : 0) - ((valid_v[k] && m_ready_v[k]) ? 1 : 0);
            end
        end
    end

    // Reference model: words leave in write order; last marks every
    // LINE_WORDS-th word since reset.
    logic [31:0] exp_q [NI][$];
    int lcnt   [NI];
    int rd_idx [NI];

    task automatic model_pop(input int k, output logic [32:0] e);
        logic [31:0] d;
        d = exp_q[k].pop_front();
        e = {((lcnt[k] % lw_of(k)) == lw_of(k) - 1), d};
        lcnt[k]++;
    endtask

    task automatic load(input int k, input int n, input bit seq, input int base);
        @(negedge clk_tb);
        for (int i = 0; i < n; i++) begin
            logic [31:0] v;
            v = seq ? 32'(base + i) : $urandom;
            fmem[k][(wp[k] + i) % 4096] = v;
            exp_q[k].push_back(v);
        end
        wp[k] = wp[k] + n;
    endtask

    task automatic wait_out(input int k, input int n, input int limit, output bit ok);
        int c = 0;
        while ((out_q[k].size() - rd_idx[k] < n) && c < limit) begin
            @(negedge clk_tb);
            c++;
        end
        ok = (out_q[k].size() - rd_idx[k] >= n);
    endtask

    task automatic test_reset();
        tb_rst = 1'b0;
        repeat (3) @(posedge clk_tb);
        #1;
        for (int k = 0; k < NI; k++) begin
            logic [35:0] got;
            got = {rd_en[k], valid_v[k], last_v[k], busy_v[k], data_v[k]};
            checks++;
            if (got !== 36'd0) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got {rd_en,valid,last,busy,data}=%h want 0", k, got);
            end
        end
        tb_rst = 1'b1;
        @(posedge clk_tb);
        #1;
    endtask

    task automatic test_throughput(input int k);
        int fe = -1, fv = -1, la = -1, c = 0;
        logic [32:0] e, got;
        enable[k] = 1'b1;
        m_ready_v[k] = 1'b1;
        load(k, 1024, 1'b1, 1);
        while ((out_q[k].size() - rd_idx[k] < 1024) && c < 3000) begin
            @(negedge clk_tb);
            if (fe < 0 && !fempty[k]) fe = c;
            if (fv < 0 && valid_v[k]) fv = c;
            if (valid_v[k] && m_ready_v[k]) la = c;
            c++;
        end
        enable[k] = 1'b0;
        checks++;
        if (out_q[k].size() - rd_idx[k] != 1024) begin
            failures++;
            $display("FAIL tput_count dut%0d got %0d words want 1024", k, out_q[k].size() - rd_idx[k]);
        end
        checks++;
        if (fv - fe != lat_of(k) + 1) begin
            failures++;
            $display("FAIL first_latency dut%0d got %0d cycles want %0d", k, fv - fe, lat_of(k) + 1);
        end
        checks++;
        if (la - fv != 1023) begin
            failures++;
            $display("FAIL tput_rate dut%0d got span %0d want 1023", k, la - fv);
        end
        for (int j = 0; j < 1024 && rd_idx[k] < out_q[k].size(); j++) begin
            model_pop(k, e);
            got = out_q[k][rd_idx[k]];
            rd_idx[k]++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL tput_word dut%0d idx %0d got %h want %h", k, j, got, e);
            end
        end
    endtask

    task automatic test_random_ready();
        int c = 0;
        logic [32:0] e, got;
        enable[1] = 1'b1;
        load(1, 300, 1'b0, 0);
        while ((out_q[1].size() - rd_idx[1] < 300) && c < 4000) begin
            @(posedge clk_tb);
            #1;
            m_ready_v[1] = $urandom_range(0, 1);
            c++;
        end
        @(posedge clk_tb);
        #1;
        m_ready_v[1] = 1'b1;
        enable[1] = 1'b0;
        checks++;
        if (out_q[1].size() - rd_idx[1] != 300) begin
            failures++;
            $display("FAIL rand_count got %0d words want 300", out_q[1].size() - rd_idx[1]);
        end
        for (int j = 0; j < 300 && rd_idx[1] < out_q[1].size(); j++) begin
            model_pop(1, e);
            got = out_q[1][rd_idx[1]];
            rd_idx[1]++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL rand_word idx %0d got %h want %h", j, got, e);
            end
        end
    endtask

    task automatic test_line_words();
        bit ok;
        int nlast = 0;
        logic [32:0] e, got;
        enable[2] = 1'b1;
        m_ready_v[2] = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            int n;
            n = (pass == 0) ? 10 : 2;
            load(2, n, 1'b1, 5001 + pass * 10);
            wait_out(2, n, 100, ok);
            checks++;
            if (!ok) begin
                failures++;
                $display("FAIL line_timeout pass %0d got %0d words want %0d", pass, out_q[2].size() - rd_idx[2], n);
            end
            for (int j = 0; j < n && rd_idx[2] < out_q[2].size(); j++) begin
                model_pop(2, e);
                got = out_q[2][rd_idx[2]];
                rd_idx[2]++;
                nlast += got[32] ? 1 : 0;
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL line_word pass %0d idx %0d got %h want %h", pass, j, got, e);
                end
            end
        end
        enable[2] = 1'b0;
        checks++;
        if (nlast != 3) begin
            failures++;
            $display("FAIL line_last_count got %0d want 3", nlast);
        end
    endtask

    task automatic test_enable_drop();
        int base_rd, issued, hi = 0, c = 0, n;
        bit ok;
        logic [32:0] e, got;
        base_rd = nrd[1];
        m_ready_v[1] = 1'b1;
        enable[1] = 1'b1;
        load(1, 20, 1'b1, 9001);
        repeat (6) @(posedge clk_tb);
        #1;
        issued = nrd[1] - base_rd;
        enable[1] = 1'b0;
        while (c < 30) begin
            @(negedge clk_tb);
            if (!busy_v[1]) break;
            hi += rd_en[1] ? 1 : 0;
            c++;
        end
        checks++;
        if (busy_v[1] !== 1'b0) begin
            failures++;
            $display("FAIL drop_busy got busy=%b want 0", busy_v[1]);
        end
        repeat (5) begin
            @(negedge clk_tb);
            hi += rd_en[1] ? 1 : 0;
        end
        checks++;
        if (hi != 0) begin
            failures++;
            $display("FAIL drop_rd_en got %0d strobes want 0", hi);
        end
        n = out_q[1].size() - rd_idx[1];
        checks++;
        if (n != issued) begin
            failures++;
            $display("FAIL drop_count got %0d words want %0d", n, issued);
        end
        for (int j = 0; j < n; j++) begin
            model_pop(1, e);
            got = out_q[1][rd_idx[1]];
            rd_idx[1]++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL drop_word idx %0d got %h want %h", j, got, e);
            end
        end
        // Re-enable: the rest of the FIFO continues with no gap in the sequence.
        n = exp_q[1].size();
        @(posedge clk_tb);
        #1;
        enable[1] = 1'b1;
        wait_out(1, n, 200, ok);
        enable[1] = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL resume_timeout got %0d words want %0d", out_q[1].size() - rd_idx[1], n);
        end
        for (int j = 0; j < n && rd_idx[1] < out_q[1].size(); j++) begin
            model_pop(1, e);
            got = out_q[1][rd_idx[1]];
            rd_idx[1]++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL resume_word idx %0d got %h want %h", j, got, e);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n, disc;
        bit ok;
        logic [35:0] outs;
        logic [32:0] e, got;
        enable[2] = 1'b1;
        m_ready_v[2] = 1'b1;
        load(2, 40, 1'b1, 7001);
        repeat (8) @(posedge clk_tb);
        #1;
        n = out_q[2].size() - rd_idx[2];
        for (int j = 0; j < n; j++) begin
            model_pop(2, e);
            got = out_q[2][rd_idx[2]];
            rd_idx[2]++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL prereset_word idx %0d got %h want %h", j, got, e);
            end
        end
        // Words read from the FIFO but not yet accepted are lost by the reset.
        disc = outst[2];
        for (int j = 0; j < disc; j++) void'(exp_q[2].pop_front());
        lcnt[2] = 0;
        tb_rst = 1'b0;
        #1;
        outs = {rd_en[2], valid_v[2], last_v[2], busy_v[2], data_v[2]};
        checks++;
        if (outs !== 36'd0) begin
            failures++;
            $display("FAIL midreset_outputs got {rd_en,valid,last,busy,data}=%h want 0", outs);
        end
        repeat (2) @(posedge clk_tb);
        #1;
        tb_rst = 1'b1;
        n = exp_q[2].size();
        wait_out(2, n, 300, ok);
        enable[2] = 1'b0;
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL postreset_timeout got %0d words want %0d", out_q[2].size() - rd_idx[2], n);
        end
        for (int j = 0; j < n && rd_idx[2] < out_q[2].size(); j++) begin
            model_pop(2, e);
            got = out_q[2][rd_idx[2]];
            rd_idx[2]++;
            checks++;
            if (got !== e) begin
                failures++;
                $display("FAIL postreset_word idx %0d got %h want %h", j, got, e);
            end
        end
    endtask

    task automatic test_monitors();
        repeat (3) @(posedge clk_tb);
        #1;
        checks++;
        if (viol_fifo != 0) begin
            failures++;
            $display("FAIL empty_read got %0d reads of an empty FIFO want 0", viol_fifo);
        end
        checks++;
        if (viol_mon != 0) begin
            failures++;
            $display("FAIL stream_protocol got %0d credit/busy/stall violations want 0", viol_mon);
        end
    endtask

    initial begin
        test_reset();
        test_throughput(0);
        test_throughput(1);
        test_random_ready();
        test_line_words();
        test_enable_drop();
        test_reset_mid_burst();
        test_monitors();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
